// File: rtl/aftab_booth_multiplier.sv
// Sequential radix-2 Booth multiplier: signed size x size -> 2*size product,
// one ADD/SHIFT pair per multiplier bit, startMul/doneMul handshake.
module aftab_booth_multiplier #(
  parameter int size = 33
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                startMul,
  input  logic [size-1:0]     M,
  input  logic [size-1:0]     Q,
  output logic                busy,
  output logic                doneMul,
  output logic [2*size-1:0]   product
);

  localparam int CW = $clog2(size) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [size:0]   a_q, a_d;
  logic [size:0]   m_q, m_d;
  logic [size-1:0] qr_q, qr_d;
  logic            q1_q, q1_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    qr_d    = qr_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (startMul) begin
          m_d     = {M[size-1], M};
          qr_d    = Q;
          a_d     = '0;
          q1_d    = 1'b0;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        // A is one bit wider than the operands, so neither path can overflow
        case ({qr_q[0], q1_q})
          2'b01:   a_d = a_q + m_q;
          2'b10:   a_d = a_q - m_q;
          default: a_d = a_q;
        endcase
        state_d = SHIFT;
      end
      SHIFT: begin
        a_d     = {a_q[size], a_q[size:1]};
        qr_d    = {a_q[0], qr_q[size-1:1]};
        q1_d    = qr_q[0];
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(size - 1)) ? DONE : ADD;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      qr_q    <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      qr_q    <= qr_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign doneMul = done_q;
  assign product = {a_q[size-1:0], qr_q};

endmodule

// File: tb/tb_aftab_booth_multiplier.sv
// Directed and randomized checks of aftab_booth_multiplier (size = 33)
// against a plain signed-multiply reference.
module tb_aftab_booth_multiplier;

  localparam int SZ  = 33;
  localparam int LAT = 2 * SZ + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            startMul = 1'b0;
  logic [SZ-1:0]   M = '0;
  logic [SZ-1:0]   Q = '0;
  logic            busy;
  logic            doneMul;
  logic [2*SZ-1:0] product;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  aftab_booth_multiplier #(.size(SZ)) dut (
    .clk(clk), .rst(rst), .startMul(startMul), .M(M), .Q(Q),
    .busy(busy), .doneMul(doneMul), .product(product)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (doneMul) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [2*SZ-1:0] obs, input logic [2*SZ-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*SZ-1:0] ref_mul(input logic [SZ-1:0] m, input logic [SZ-1:0] q);
    logic signed [2*SZ-1:0] ms, qs;
    ms = {{SZ{m[SZ-1]}}, m};
    qs = {{SZ{q[SZ-1]}}, q};
    return ms * qs;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Full handshake: start, measure latency, check product and single done pulse
  task automatic run_mul(input logic [SZ-1:0] m, input logic [SZ-1:0] q, input string tag);
    logic [2*SZ-1:0] exp;
    int lat, d0;
    exp = ref_mul(m, q);
    @(negedge clk);
    startMul = 1'b1; M = m; Q = q; d0 = done_cnt;
    @(negedge clk);
    startMul = 1'b0; lat = 1;
    chk({tag, "_busy_rise"}, 66'(busy), 66'd1);
    while (!doneMul && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 66'(lat), 66'(LAT));
    chk({tag, "_product"}, product, exp);
    @(negedge clk);
    chk({tag, "_one_done"}, 66'(done_cnt - d0), 66'd1);
    chk({tag, "_idle_hold"}, {65'(busy), doneMul} == '0 ? product : ~exp, exp);
  endtask

  initial begin
    logic [SZ-1:0] rm, rq;
    int c, d0;

    // 1: reset then idle
    do_reset();
    for (int i = 0; i < 10; i++) begin
      chk("idle_outputs", {busy, doneMul, product[2*SZ-3:0]}, 66'(0));
      chk("idle_prod_top", 66'(product[2*SZ-1:2*SZ-2]), 66'd0);
      @(negedge clk);
    end

    // 2: small positive, product held across idle
    run_mul(33'd3, 33'd5, "pos3x5");
    repeat (5) @(negedge clk);
    chk("pos_held", product, 66'd15);

    // 3: signed corners
    run_mul('1, '1, "neg1xneg1");
    run_mul(-33'sd7, 33'd6, "neg7x6");
    chk("neg7x6_lit", product, 66'h3_FFFF_FFFF_FFFF_FFD6);
    run_mul(33'h1_0000_0000, 33'h1_0000_0000, "minxmin");
    chk("minxmin_lit", product, 66'h1_0000_0000_0000_0000);
    run_mul(33'h1_2345_6789, 33'd0, "xzero");

    // 4: starts outside IDLE are dropped; IDLE start right after DONE is accepted
    @(negedge clk);
    startMul = 1'b1; M = 33'd3; Q = 33'd5; d0 = done_cnt;
    c = 0;
    while (c < 140) begin
      @(negedge clk);
      c++;
      if (c == LAT) chk("busyprot_done67", 66'(doneMul), 66'd1);
      if (c == LAT) chk("busyprot_prod15", product, 66'd15);
      if (c == 2 * LAT + 1) chk("busyprot_done135", 66'(doneMul), 66'd1);
      if (c == 2 * LAT + 1) chk("busyprot_prod81", product, 66'd81);
      startMul = (c == 10 || c == 66 || c == 67 || c == 68);
      M = (c == 10 || c == 66 || c == 67 || c == 68) ? 33'd9 : 33'd3;
      Q = M;
    end
    chk("busyprot_done_count", 66'(done_cnt - d0), 66'd2);

    // 5: reset mid-operation
    @(negedge clk);
    startMul = 1'b1; M = 33'd100; Q = 33'd200; d0 = done_cnt;
    repeat (30) begin
      @(negedge clk);
      startMul = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("abort_busy", 66'(busy), 66'd0);
    chk("abort_product", product, 66'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    chk("abort_no_done", 66'(done_cnt - d0), 66'd0);
    run_mul(33'd100, 33'd200, "after_abort");
    chk("after_abort_lit", product, 66'd20000);

    // 6: randomized
    for (int n = 0; n < 1000; n++) begin
      rm = {1'($urandom_range(0, 1)), 32'($urandom())};
      rq = {1'($urandom_range(0, 1)), 32'($urandom())};
      if (n % 50 == 0) rm = 33'h1_0000_0000;
      if (n % 70 == 1) rq = '1;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_mul(rm, rq, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
